// File: rtl/sliding_window_packer.sv
// Packs a serial sample stream into NP-sample blocks for a P-block sliding-window RAM,
// rotating the write address and reading back the oldest block once the window is full.
module sliding_window_packer #(
    parameter int P       = 2,
    parameter int NP      = 10,
    parameter int NB_DATA = 32
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic [NB_DATA-1:0]         i_sample,
    output logic                       o_ram_enable,
    output logic                       o_ram_wenable,
    output logic [$clog2(P)-1:0]       o_ram_write_addr,
    output logic [$clog2(P)-1:0]       o_ram_read_addr,
    output logic [NP*NB_DATA-1:0]      o_ram_data,
    output logic [$clog2(P+1)-1:0]     o_fill_count,
    output logic                       o_window_ready,
    output logic                       o_window_valid
);

    localparam int AW = $clog2(P);
    localparam int FW = $clog2(P+1);
    localparam int SW = $clog2(NP);
    localparam logic [AW-1:0] ADDR_LAST = AW'(P-1);
    localparam logic [SW-1:0] LANE_LAST = SW'(NP-1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(P);
    localparam logic [FW-1:0] FILL_LAST = FW'(P-1);

    typedef enum logic [1:0] {ST_FILL, ST_LAST, ST_FULL} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [FW-1:0]         r_fill;
    logic [FW-1:0]         w_fill_next;
    logic [SW-1:0]         r_scnt;
    logic [NB_DATA-1:0]    r_lanes [NP];
    logic [NP*NB_DATA-1:0] w_block;
    logic [NP*NB_DATA-1:0] r_data_p1;
    logic                  r_en;
    logic                  r_wen_p1;
    logic                  r_wvld_p2;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rd_addr_p1;
    logic                  w_last;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + AW'(1);
    endfunction

    // p0: sample accepted; the lane NP-1 sample completes the block this cycle
    assign w_last = i_valid && (r_scnt == LANE_LAST);

    always_comb begin
        w_block = '0;
        for (int k = 0; k < NP; k++) begin
            w_block[k*NB_DATA +: NB_DATA] = (k == NP-1) ? i_sample : r_lanes[k];
        end
    end

    always_ff @(posedge clock) begin
        if (i_valid) begin
            r_lanes[r_scnt] <= i_sample;
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_en         <= 1'b0;
            r_scnt       <= '0;
            r_wen_p1     <= 1'b0;
            r_wvld_p2    <= 1'b0;
            r_wptr       <= '0;
            r_rd_addr_p1 <= '0;
            r_data_p1    <= '0;
            r_fill       <= '0;
        end else begin
            r_en      <= 1'b1;
            r_wen_p1  <= w_last;
            r_wvld_p2 <= r_wen_p1 && (r_state != ST_FILL);
            r_fill    <= w_fill_next;
            if (i_valid) begin
                r_scnt <= (r_scnt == LANE_LAST) ? '0 : r_scnt + SW'(1);
            end
            // p1: block, write and oldest-block read address presented together
            if (w_last) begin
                r_data_p1 <= w_block;
                if (r_state != ST_FILL) begin
                    r_rd_addr_p1 <= addr_inc(r_wptr);
                end
            end
            if (r_wen_p1) begin
                r_wptr <= addr_inc(r_wptr);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        if (r_wen_p1) begin
            if (r_fill != FILL_MAX) begin
                w_fill_next = r_fill + FW'(1);
            end
            case (r_state)
                ST_FILL: w_state_next = (r_fill + FW'(1) == FILL_LAST) ? ST_LAST : ST_FILL;
                ST_LAST: w_state_next = ST_FULL;
                default: w_state_next = ST_FULL;
            endcase
        end
    end

    // p2: RAM read data for the oldest block is valid
    assign o_ram_enable     = r_en;
    assign o_ram_wenable    = r_wen_p1;
    assign o_ram_write_addr = r_wptr;
    assign o_ram_read_addr  = r_rd_addr_p1;
    assign o_ram_data       = r_data_p1;
    assign o_fill_count     = r_fill;
    assign o_window_ready   = (r_state == ST_FULL);
    assign o_window_valid   = r_wvld_p2;

endmodule
